demux_reg: RTL and testbench
============================

Name: demux_reg

Overview:
- Registered 1-to-2 demultiplexer: the inverse of the 2x1 operand mux in the RSA datapath.
- Takes one N-bit word stream with a valid/ready handshake and steers each word to one of two output channels, chosen by a select bit sampled with the word.
- Used to return a modular-multiplier result to either the accumulator path (channel 1) or the base/square path (channel 2).
- Each output channel has its own one-entry holding register, so a stalled channel never blocks traffic to the other.

Parameters:
- N, 6, data width of the input word and of both output words.
- CNT_W, 8, width of the transfer counters; used only when DEMUX_CNT_EN is defined.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- In  input  N  input data word.
- sel  input  1  destination select, sampled with In: 0 routes to channel 1, 1 routes to channel 2.
- in_valid  input  1  In/sel are valid this cycle.
- in_ready  output  1  demux accepts the word this cycle.
- out1  output  N  channel 1 data.
- out1_valid  output  1  channel 1 holds a word.
- out1_ready  input  1  channel 1 consumer accepts this cycle.
- out2  output  N  channel 2 data.
- out2_valid  output  1  channel 2 holds a word.
- out2_ready  input  1  channel 2 consumer accepts this cycle.
- cnt1  output  CNT_W  words delivered on channel 1 (DEMUX_CNT_EN only).
- cnt2  output  CNT_W  words delivered on channel 2 (DEMUX_CNT_EN only).

Behaviour:
- Reset (rst_n low, asynchronous): out1_valid=0, out2_valid=0, out1=0, out2=0, cnt1=0, cnt2=0.
- Release of reset is synchronous to clk.
- Per-channel state machine, k in {1,2}: EMPTY (outk_valid=0) or FULL (outk_valid=1).
- Accept: acc = in_valid & in_ready.
- in_ready is combinational: sel ? (!out2_valid | out2_ready) : (!out1_valid | out1_ready).
- in_ready depends on sel and the downstream ready of the selected channel only.
- Drain: dk = outk_valid & outk_ready.
- Channel 1 transitions:
  - EMPTY, acc & sel=0: capture In into out1 -> FULL.
  - FULL, d1 & !(acc & sel=0): -> EMPTY; out1 data keeps its last value.
  - FULL, d1 & acc & sel=0: stays FULL and loads the new word (back-to-back, full throughput).
  - FULL, !d1: holds; out1 is stable while out1_valid=1 and out1_ready=0.
- Channel 2: identical to channel 1, with sel=1.
- Latency: a word accepted on cycle t is visible on outk/outk_valid at t+1.
- Throughput: 1 word/cycle per channel when downstream is always ready.
- Channel independence: channel 1 stalled while channel 2 empty -> a sel=1 word is still accepted; a sel=0 word waits.
- Simultaneous events: drain on one channel and accept to the other in the same cycle are independent.
- At most one channel is loaded per cycle.
- in_valid=0: sel and In are ignored.
- Reset mid-transfer: held words are discarded and both channels return to EMPTY immediately.
- Upstream rule: In/sel must be held stable while in_valid=1 & in_ready=0. The block does not check this.

Optional Feature:
- Macro: DEMUX_CNT_EN.
- Defined:
  - cnt1/cnt2 ports exist.
  - cntk increments by 1 on every dk, wrapping from 2^CNT_W-1 to 0.
  - Counters clear on reset.
- Undefined:
  - cnt1/cnt2 ports and their counters are absent.
  - All other behaviour is identical.

Test Plan:
- Reset, both readies=1: hold rst_n=0 three cycles -> out1_valid=out2_valid=0, out1=out2=0, in_ready=1. Release, send In=6'h15 sel=0 -> out1=6'h15, out1_valid=1 next cycle, out2_valid stays 0.
- Streaming: out1_ready=out2_ready=1; send 6'h01,6'h02,6'h03 with sel=1,0,1 on consecutive cycles -> out2 shows 01, out1 shows 02, out2 shows 03, each one cycle after acceptance; in_ready=1 throughout.
- Backpressure: out1_ready=0; send 6'h2A sel=0, then 6'h11 sel=0 -> first accepted, second sees in_ready=0, out1 holds 6'h2A. Raise out1_ready -> 6'h11 accepted that cycle, appears next cycle.
- Independence: channel 1 FULL with out1_ready=0; send 6'h3F sel=1 -> in_ready=1, out2=6'h3F next cycle, out1 unchanged.
- Reset mid-operation: both channels FULL and stalled; pulse rst_n low between clock edges -> out1_valid=out2_valid=0 immediately, before the next clk edge.
- DEMUX_CNT_EN, CNT_W=2: deliver 5 words on channel 2 -> cnt2 sequence 1,2,3,0,1; cnt1 stays 0.

Source files
------------

// File: rtl/demux_reg.sv
// Registered 1-to-2 demultiplexer with a one-entry holding register per output channel.
// Optional per-channel delivery counters are compiled in when DEMUX_CNT_EN is defined.
module demux_reg #(
  parameter int N     = 6,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     In,
  input  logic             sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N-1:0]     out1,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [N-1:0]     out2,
  output logic             out2_valid,
  input  logic             out2_ready
`ifdef DEMUX_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ch_state_t;

  ch_state_t ch1_state_r, ch1_next_s;
  ch_state_t ch2_state_r, ch2_next_s;

  logic acc_s;
  logic ld1_s;
  logic ld2_s;
  logic d1_s;
  logic d2_s;

  assign out1_valid = (ch1_state_r == FULL);
  assign out2_valid = (ch2_state_r == FULL);

  // Readiness looks only at the channel the current word is headed for.
  assign in_ready = sel ? (~out2_valid | out2_ready) : (~out1_valid | out1_ready);
  assign acc_s    = in_valid & in_ready;
  assign ld1_s    = acc_s & ~sel;
  assign ld2_s    = acc_s & sel;
  assign d1_s     = out1_valid & out1_ready;
  assign d2_s     = out2_valid & out2_ready;

  // Channel state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch1_state_r <= EMPTY;
      ch2_state_r <= EMPTY;
    end else begin
      ch1_state_r <= ch1_next_s;
      ch2_state_r <= ch2_next_s;
    end
  end

  // Channel 1 next state: a load wins over a drain, giving back-to-back throughput
  always_comb begin
    ch1_next_s = ch1_state_r;
    case (ch1_state_r)
      EMPTY: begin
        if (ld1_s) ch1_next_s = FULL;
        else       ch1_next_s = EMPTY;
      end
      FULL: begin
        if (ld1_s)     ch1_next_s = FULL;
        else if (d1_s) ch1_next_s = EMPTY;
        else           ch1_next_s = FULL;
      end
      default: ch1_next_s = EMPTY;
    endcase
  end

  // Channel 2 next state, same rules with the opposite select
  always_comb begin
    ch2_next_s = ch2_state_r;
    case (ch2_state_r)
      EMPTY: begin
        if (ld2_s) ch2_next_s = FULL;
        else       ch2_next_s = EMPTY;
      end
      FULL: begin
        if (ld2_s)     ch2_next_s = FULL;
        else if (d2_s) ch2_next_s = EMPTY;
        else           ch2_next_s = FULL;
      end
      default: ch2_next_s = EMPTY;
    endcase
  end

  // Output data registers: data keeps its last value after a drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out1 <= '0;
      out2 <= '0;
    end else begin
      if (ld1_s) out1 <= In;
      else       out1 <= out1;
      if (ld2_s) out2 <= In;
      else       out2 <= out2;
    end
  end

`ifdef DEMUX_CNT_EN
  // Delivery counters, wrapping naturally at 2^CNT_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt1 <= '0;
      cnt2 <= '0;
    end else begin
      if (d1_s) cnt1 <= cnt1 + {{(CNT_W-1){1'b0}}, 1'b1};
      else      cnt1 <= cnt1;
      if (d2_s) cnt2 <= cnt2 + {{(CNT_W-1){1'b0}}, 1'b1};
      else      cnt2 <= cnt2;
    end
  end
`else
  // Counter width is only meaningful with counters built; keep it a legal value anyway
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule

// File: tb/tb_demux_reg.sv
// Directed self-checking bench for demux_reg; counter checks compile in with DEMUX_CNT_EN.
module tb_demux_reg;

  logic       clk;
  logic       rst_n;
  logic [5:0] In;
  logic       sel;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] out1;
  logic       out1_valid;
  logic       out1_ready;
  logic [5:0] out2;
  logic       out2_valid;
  logic       out2_ready;
`ifdef DEMUX_CNT_EN
  logic [1:0] cnt1;
  logic [1:0] cnt2;
`endif

  int checks;
  int fails;

  demux_reg #(.N(6), .CNT_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .In         (In),
    .sel        (sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out1       (out1),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out2       (out2),
    .out2_valid (out2_valid),
    .out2_ready (out2_ready)
`ifdef DEMUX_CNT_EN
    ,
    .cnt1       (cnt1),
    .cnt2       (cnt2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; sel = 1'b0; In = 6'h00;
    out1_ready = 1'b1; out2_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out1_valid !== 1'b0) begin fails++; $display("FAIL rst_out1_valid got %b exp 0", out1_valid); end
    checks++; if (out2_valid !== 1'b0) begin fails++; $display("FAIL rst_out2_valid got %b exp 0", out2_valid); end
    checks++; if (out1 !== 6'h00) begin fails++; $display("FAIL rst_out1 got %h exp 00", out1); end
    checks++; if (out2 !== 6'h00) begin fails++; $display("FAIL rst_out2 got %h exp 00", out2); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
    rst_n = 1'b1;
    tick();
    In = 6'h15; sel = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (out1 !== 6'h15) begin fails++; $display("FAIL first_out1 got %h exp 15", out1); end
    checks++; if (out1_valid !== 1'b1) begin fails++; $display("FAIL first_out1_valid got %b exp 1", out1_valid); end
    checks++; if (out2_valid !== 1'b0) begin fails++; $display("FAIL first_out2_valid got %b exp 0", out2_valid); end
    tick();
  endtask

  task automatic test_streaming();
    logic [5:0] words [3];
    logic       sels  [3];
    words[0] = 6'h01; words[1] = 6'h02; words[2] = 6'h03;
    sels[0]  = 1'b1;  sels[1]  = 1'b0;  sels[2]  = 1'b1;
    out1_ready = 1'b1; out2_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      In = words[i]; sel = sels[i]; in_valid = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL stream_in_ready[%0d] got %b exp 1", i, in_ready); end
      tick();
      if (sels[i]) begin
        checks++; if (out2 !== words[i] || out2_valid !== 1'b1) begin fails++; $display("FAIL stream_out2[%0d] got %h/%b exp %h/1", i, out2, out2_valid, words[i]); end
      end else begin
        checks++; if (out1 !== words[i] || out1_valid !== 1'b1) begin fails++; $display("FAIL stream_out1[%0d] got %h/%b exp %h/1", i, out1, out1_valid, words[i]); end
      end
    end
    in_valid = 1'b0;
    checks++; if (out1_valid !== 1'b0) begin fails++; $display("FAIL stream_out1_drained got %b exp 0", out1_valid); end
    tick();
  endtask

  task automatic test_backpressure();
    out1_ready = 1'b0; out2_ready = 1'b1;
    In = 6'h2A; sel = 1'b0; in_valid = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_first_ready got %b exp 1", in_ready); end
    tick();
    In = 6'h11;
    #1;
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_second_ready got %b exp 0", in_ready); end
    tick();
    checks++; if (out1 !== 6'h2A || out1_valid !== 1'b1) begin fails++; $display("FAIL bp_hold got %h/%b exp 2a/1", out1, out1_valid); end
    out1_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready got %b exp 1", in_ready); end
    tick();
    in_valid = 1'b0; out1_ready = 1'b0;
    checks++; if (out1 !== 6'h11 || out1_valid !== 1'b1) begin fails++; $display("FAIL bp_second_word got %h/%b exp 11/1", out1, out1_valid); end
  endtask

  task automatic test_independence();
    In = 6'h05; sel = 1'b0; in_valid = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL ind_ch1_blocked got %b exp 0", in_ready); end
    In = 6'h3F; sel = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL ind_ch2_ready got %b exp 1", in_ready); end
    tick();
    in_valid = 1'b0; out2_ready = 1'b0;
    checks++; if (out2 !== 6'h3F || out2_valid !== 1'b1) begin fails++; $display("FAIL ind_out2 got %h/%b exp 3f/1", out2, out2_valid); end
    checks++; if (out1 !== 6'h11 || out1_valid !== 1'b1) begin fails++; $display("FAIL ind_out1_kept got %h/%b exp 11/1", out1, out1_valid); end
  endtask

  task automatic test_reset_mid();
    tick();
    checks++; if (out1_valid !== 1'b1 || out2_valid !== 1'b1) begin fails++; $display("FAIL mid_both_full got %b%b exp 11", out1_valid, out2_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out1_valid !== 1'b0 || out2_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_valid got %b%b exp 00", out1_valid, out2_valid); end
    checks++; if (out1 !== 6'h00 || out2 !== 6'h00) begin fails++; $display("FAIL mid_rst_data got %h/%h exp 00/00", out1, out2); end
    @(negedge clk);
    rst_n = 1'b1; out1_ready = 1'b1; out2_ready = 1'b1;
    tick();
  endtask

`ifdef DEMUX_CNT_EN
  task automatic test_counters();
    logic [1:0] exp_cnt [5];
    exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd0; exp_cnt[4] = 2'd1;
    out1_ready = 1'b1; out2_ready = 1'b1;
    checks++; if (cnt2 !== 2'd0) begin fails++; $display("FAIL cnt2_start got %0d exp 0", cnt2); end
    for (int i = 0; i < 5; i++) begin
      In = 6'h20 + 6'(i); sel = 1'b1; in_valid = 1'b1;
      tick();
      if (i > 0) begin
        checks++; if (cnt2 !== exp_cnt[i-1]) begin fails++; $display("FAIL cnt2[%0d] got %0d exp %0d", i-1, cnt2, exp_cnt[i-1]); end
      end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (cnt2 !== exp_cnt[4]) begin fails++; $display("FAIL cnt2[4] got %0d exp %0d", cnt2, exp_cnt[4]); end
    checks++; if (cnt1 !== 2'd0) begin fails++; $display("FAIL cnt1_idle got %0d exp 0", cnt1); end
  endtask
`endif

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_independence();
    test_reset_mid();
`ifdef DEMUX_CNT_EN
    test_counters();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
